// File: rtl/keypad_scan_if.sv
// Keypad-side and event-side signals of the 4x4 keypad scanner.
// master = scanner (drives columns, reports key events); slave = keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_release,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_release,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchronisation, full-frame
// debounce and single-key press/release event generation.
module keypad_scan #(
  parameter int scan_period     = 200000,
  parameter int debounce_frames = 4
) (
  input  logic           clk_100mhz,
  input  logic           rst_n,
  keypad_scan_if.master  kp
);

  localparam int TW = (scan_period > 1) ? $clog2(scan_period) : 1;
  localparam int CW = $clog2(debounce_frames + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(scan_period - 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(debounce_frames);

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} frame_cls_e;
  typedef enum logic {IDLE, HELD} state_e;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_out_q, col_out_d;
  logic [15:0]   snap_q, snap_d;
  logic          frame_done_q, frame_done_d;

  frame_cls_e    cand_cls_q, cand_cls_d;
  logic [3:0]    cand_code_q, cand_code_d;
  logic [CW-1:0] stable_q, stable_d;

  state_e        state_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q, key_release_q, key_held_q;

  logic [4:0]    zero_cnt;
  logic [3:0]    zero_idx;
  frame_cls_e    cls;
  logic          press_ok, release_ok;

  // Snapshot bit index is {row, col}, so a lone zero's index is the key code.
  always_comb begin
    tick_d       = tick_q + 1'b1;
    col_d        = col_q;
    col_out_d    = col_out_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    if (tick_q == TICK_LAST) begin
      tick_d       = '0;
      col_d        = col_q + 2'd1;
      col_out_d    = ~(4'b0001 << col_d);
      frame_done_d = (col_q == 2'd3);
      for (int r = 0; r < 4; r++) begin
        snap_d[{2'(r), col_q}] = row_sync_q[r];
      end
    end
  end

  always_comb begin
    zero_cnt = '0;
    zero_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (!snap_q[i]) begin
        zero_cnt = zero_cnt + 5'd1;
        zero_idx = 4'(i);
      end
    end
    if (zero_cnt == 5'd0)      cls = CLS_NONE;
    else if (zero_cnt == 5'd1) cls = CLS_SINGLE;
    else                       cls = CLS_MULTI;
  end

  // A cleared candidate is parked as MULTI so no following frame can match it.
  always_comb begin
    cand_cls_d  = cand_cls_q;
    cand_code_d = cand_code_q;
    stable_d    = stable_q;
    if (frame_done_q) begin
      if (cls == CLS_MULTI) begin
        cand_cls_d  = CLS_MULTI;
        cand_code_d = '0;
        stable_d    = '0;
      end else if (cls == cand_cls_q && (cls == CLS_NONE || zero_idx == cand_code_q)) begin
        stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
      end else begin
        cand_cls_d  = cls;
        cand_code_d = zero_idx;
        stable_d    = CW'(1);
      end
    end
  end

  assign press_ok   = frame_done_q && (cls == CLS_SINGLE) && (stable_d == STABLE_MAX);
  assign release_ok = frame_done_q && (cls == CLS_NONE)   && (stable_d == STABLE_MAX);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q   <= 4'hF;
      row_sync_q   <= 4'hF;
      tick_q       <= '0;
      col_q        <= 2'd0;
      col_out_q    <= 4'b1110;
      snap_q       <= 16'hFFFF;
      frame_done_q <= 1'b0;
      cand_cls_q   <= CLS_MULTI;
      cand_code_q  <= '0;
      stable_q     <= '0;
    end else begin
      row_meta_q   <= kp.row_in;
      row_sync_q   <= row_meta_q;
      tick_q       <= tick_d;
      col_q        <= col_d;
      col_out_q    <= col_out_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
      cand_cls_q   <= cand_cls_d;
      cand_code_q  <= cand_code_d;
      stable_q     <= stable_d;
    end
  end

  // A different key pressed while HELD only keeps the NONE count from building.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_held_q    <= 1'b0;
    end else begin
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_ok) begin
            key_code_q  <= cand_code_d;
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            state_q     <= HELD;
          end
        end
        HELD: begin
          if (release_ok) begin
            key_release_q <= 1'b1;
            key_held_q    <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kp.col_out     = col_out_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_release = key_release_q;
  assign kp.key_held    = key_held_q;

endmodule
